// File: rtl/calc_pkg.sv
// Shared calculator definitions: core status codes and active-low seven-segment glyphs.
// Glyph bit order is {dp,g,f,e,d,c,b,a}; a 0 lights the segment.
package calc_pkg;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit encoder: 4-bit value plus blank flag to active-low segments.
// Non-decimal values render as a dash so corrupted digits are visible rather than misleading.
module seg7_encode
  import calc_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/calc_display.sv
// Display back-end: captures the core's digit stream into a shadow buffer, commits it on the
// ready edge, and scans the committed digits onto eight common-anode displays.
module calc_display
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_ZEROS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [7:0][3:0] shadow;
  logic [7:0][3:0] disp;
  logic            dirty;
  logic [1:0]      prev_status;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]      scan_idx;
  logic [7:0]      blank_mask;
  logic [7:0]      digit_seg;
  logic [7:0]      seg_next;
  logic            wr_en;
  logic            commit;
  logic            div_tc;

  // Status 11 is treated as busy, so bit 0 alone marks a capture cycle.
  assign wr_en  = status[0] && !pos[3];
  assign commit = (status == ST_READY) && (prev_status != ST_READY) && dirty;
  assign div_tc = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      disp        <= '0;
      dirty       <= 1'b0;
      prev_status <= ST_BUSY;
    end else begin
      prev_status <= status;
      if (wr_en) begin
        shadow[pos[2:0]] <= data;
        dirty            <= 1'b1;
      end
      if (commit) begin
        disp  <= shadow;
        dirty <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      scan_idx   <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= div_tc && (scan_idx == 3'd7);
      if (div_tc) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Walk down from the leftmost digit; a digit is blank while every digit at or above it is zero.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    blank_mask = '0;
    for (int i = 7; i >= 0; i--) begin
      all_zero      = all_zero && (disp[i] == 4'd0);
      blank_mask[i] = (BLANK_ZEROS != 0) && (i != 0) && all_zero;
    end
  end

  seg7_encode u_encode (
    .value(disp[scan_idx]),
    .blank(blank_mask[scan_idx]),
    .seg  (digit_seg)
  );

  always_comb begin
    seg_next = digit_seg;
    if (status == ST_ERRO) begin
      if (scan_idx == 3'd2)
        seg_next = SEG_E;
      else if (scan_idx < 3'd2)
        seg_next = SEG_R;
      else
        seg_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'h01 << scan_idx);
      seg <= seg_next;
    end
  end

endmodule
